// File: rtl/graphics_pkg.sv
// Shared graphics types: VRAM address width, requester ids and issue-pipeline slot.
package graphics_pkg;

   localparam int unsigned VRAM_AW = 15;
   localparam int unsigned REQ_IDW = 2;
   localparam int unsigned NUM_REQ = 3;

   typedef logic [REQ_IDW-1:0] req_id_t;

   localparam req_id_t REQ_L0  = 2'd0;
   localparam req_id_t REQ_L1  = 2'd1;
   localparam req_id_t REQ_SPR = 2'd2;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } issue_slot_t;

   // One-hot requester vector for an id; unused id encodings map to zero.
   function automatic logic [NUM_REQ-1:0] req_onehot(input req_id_t id);
      return NUM_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/vram_issue_pipe.sv
// Tracks issued reads for RAM_LATENCY cycles, then emits a registered one-hot ack
// aligned with the cycle the RAM data is valid.
module vram_issue_pipe
   import graphics_pkg::*;
#(
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_valid,
   input  req_id_t            push_id,
   output logic [NUM_REQ-1:0] ack
);

   issue_slot_t        stage_q [RAM_LATENCY];
   issue_slot_t        stage_d [RAM_LATENCY];
   logic [NUM_REQ-1:0] ack_q;
   logic [NUM_REQ-1:0] ack_d;

   always_comb begin
      stage_d[0].valid = push_valid;
      stage_d[0].id    = push_id;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      ack_d = stage_q[RAM_LATENCY-1].valid ? req_onehot(stage_q[RAM_LATENCY-1].id) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
            stage_q[i] <= '0;
         end
         ack_q <= '0;
      end else begin
         for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
         end
         ack_q <= ack_d;
      end
   end

   assign ack = ack_q;

endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the VRAM read port between layer 0, layer 1 and sprite fetch engines:
// fixed priority L0 > L1 > SPR, one outstanding read per requester, sprite starvation guard.
module vram_bus_arbiter
   import graphics_pkg::*;
#(
   parameter int unsigned RAM_LATENCY  = 1,
   parameter int unsigned SPR_MAX_WAIT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VRAM_AW-1:0] l0_bus_addr,
   input  logic               l0_bus_strobe,
   output logic               l0_bus_ack,
   input  logic [VRAM_AW-1:0] l1_bus_addr,
   input  logic               l1_bus_strobe,
   output logic               l1_bus_ack,
   input  logic [VRAM_AW-1:0] spr_bus_addr,
   input  logic               spr_bus_strobe,
   output logic               spr_bus_ack,
   output logic [31:0]        bus_rddata,
   output logic [VRAM_AW-1:0] ram_addr,
   output logic               ram_rden,
   input  logic [31:0]        ram_rddata
);

   localparam int unsigned WAIT_W = 4;

   logic [NUM_REQ-1:0] strobe;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] ack;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [VRAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic               ram_rden_q, ram_rden_d;
   logic [WAIT_W-1:0]  spr_wait_cnt_q, spr_wait_cnt_d;

   logic               grant_valid;
   req_id_t            grant_id;
   logic [VRAM_AW-1:0] grant_addr;
   logic               spr_promote;

   assign strobe      = {spr_bus_strobe, l1_bus_strobe, l0_bus_strobe};
   assign eligible    = strobe & ~pending_q;
   assign spr_promote = eligible[REQ_SPR] && (spr_wait_cnt_q == WAIT_W'(SPR_MAX_WAIT));

   // Grant selection: a starved sprite jumps the queue, else fixed priority.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = REQ_L0;
      grant_addr  = l0_bus_addr;
      if (spr_promote) begin
         grant_valid = 1'b1;
         grant_id    = REQ_SPR;
         grant_addr  = spr_bus_addr;
      end else if (eligible[REQ_L0]) begin
         grant_valid = 1'b1;
         grant_id    = REQ_L0;
         grant_addr  = l0_bus_addr;
      end else if (eligible[REQ_L1]) begin
         grant_valid = 1'b1;
         grant_id    = REQ_L1;
         grant_addr  = l1_bus_addr;
      end else if (eligible[REQ_SPR]) begin
         grant_valid = 1'b1;
         grant_id    = REQ_SPR;
         grant_addr  = spr_bus_addr;
      end
   end

   always_comb begin
      ram_addr_d     = grant_valid ? grant_addr : ram_addr_q;
      ram_rden_d     = grant_valid;
      // Ack and grant never hit the same requester in one cycle (grant needs pending clear).
      pending_d      = (pending_q & ~ack) | (grant_valid ? req_onehot(grant_id) : '0);
      spr_wait_cnt_d = spr_wait_cnt_q;
      if (!spr_bus_strobe || (grant_valid && grant_id == REQ_SPR)) begin
         spr_wait_cnt_d = '0;
      end else if (eligible[REQ_SPR] && spr_wait_cnt_q != WAIT_W'(SPR_MAX_WAIT)) begin
         spr_wait_cnt_d = spr_wait_cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr_q     <= '0;
         ram_rden_q     <= 1'b0;
         pending_q      <= '0;
         spr_wait_cnt_q <= '0;
      end else begin
         ram_addr_q     <= ram_addr_d;
         ram_rden_q     <= ram_rden_d;
         pending_q      <= pending_d;
         spr_wait_cnt_q <= spr_wait_cnt_d;
      end
   end

   vram_issue_pipe #(
      .RAM_LATENCY(RAM_LATENCY)
   ) u_issue_pipe (
      .clk        (clk),
      .rst        (rst),
      .push_valid (grant_valid),
      .push_id    (grant_id),
      .ack        (ack)
   );

   assign ram_addr    = ram_addr_q;
   assign ram_rden    = ram_rden_q;
   assign l0_bus_ack  = ack[REQ_L0];
   assign l1_bus_ack  = ack[REQ_L1];
   assign spr_bus_ack = ack[REQ_SPR];
   assign bus_rddata  = ram_rddata;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench: dut_a uses default parameters, dut_b uses RAM_LATENCY=3, SPR_MAX_WAIT=1.
module tb_vram_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [14:0] a_l0_addr, a_l1_addr, a_spr_addr, a_ram_addr;
   logic        a_l0_stb, a_l1_stb, a_spr_stb, a_l0_ack, a_l1_ack, a_spr_ack, a_ram_rden;
   logic [31:0] a_bus_rddata, a_ram_rddata;
   logic [14:0] b_l0_addr, b_l1_addr, b_spr_addr, b_ram_addr;
   logic        b_l0_stb, b_l1_stb, b_spr_stb, b_l0_ack, b_l1_ack, b_spr_ack, b_ram_rden;
   logic [31:0] b_bus_rddata, b_ram_rddata;
   logic [31:0] b_pipe [3];
   logic [2:0]  a_acks, b_acks;

   assign a_acks = {a_spr_ack, a_l1_ack, a_l0_ack};
   assign b_acks = {b_spr_ack, b_l1_ack, b_l0_ack};

   vram_bus_arbiter dut_a (
      .clk(clk), .rst(rst),
      .l0_bus_addr(a_l0_addr), .l0_bus_strobe(a_l0_stb), .l0_bus_ack(a_l0_ack),
      .l1_bus_addr(a_l1_addr), .l1_bus_strobe(a_l1_stb), .l1_bus_ack(a_l1_ack),
      .spr_bus_addr(a_spr_addr), .spr_bus_strobe(a_spr_stb), .spr_bus_ack(a_spr_ack),
      .bus_rddata(a_bus_rddata), .ram_addr(a_ram_addr), .ram_rden(a_ram_rden),
      .ram_rddata(a_ram_rddata)
   );

   vram_bus_arbiter #(.RAM_LATENCY(3), .SPR_MAX_WAIT(1)) dut_b (
      .clk(clk), .rst(rst),
      .l0_bus_addr(b_l0_addr), .l0_bus_strobe(b_l0_stb), .l0_bus_ack(b_l0_ack),
      .l1_bus_addr(b_l1_addr), .l1_bus_strobe(b_l1_stb), .l1_bus_ack(b_l1_ack),
      .spr_bus_addr(b_spr_addr), .spr_bus_strobe(b_spr_stb), .spr_bus_ack(b_spr_ack),
      .bus_rddata(b_bus_rddata), .ram_addr(b_ram_addr), .ram_rden(b_ram_rden),
      .ram_rddata(b_ram_rddata)
   );

   function automatic logic [31:0] mem_word(input logic [14:0] a);
      return (a == 15'h1234) ? 32'hDEAD_BEEF : {2'b10, a, ~a};
   endfunction

   // VRAM models: latency 1 for dut_a, latency 3 for dut_b.
   always @(posedge clk) a_ram_rddata <= a_ram_rden ? mem_word(a_ram_addr) : 32'h0;
   always @(posedge clk) begin
      b_pipe[0] <= b_ram_rden ? mem_word(b_ram_addr) : 32'h0;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign b_ram_rddata = b_pipe[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks} !== 19'h0) begin
         errors++;
         $display("FAIL reset_a: got %h expected 0", {a_ram_rden, a_ram_addr, a_acks});
      end
      checks++;
      if ({b_ram_rden, b_ram_addr, b_acks} !== 19'h0) begin
         errors++;
         $display("FAIL reset_b: got %h expected 0", {b_ram_rden, b_ram_addr, b_acks});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      a_l0_addr = 15'h1234; a_l0_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks} !== {1'b1, 15'h1234, 3'b000}) begin
         errors++;
         $display("FAIL single_issue: got %h expected %h", {a_ram_rden, a_ram_addr, a_acks}, {1'b1, 15'h1234, 3'b000});
      end
      tick();
      checks++;
      if ({a_ram_rden, a_acks, a_bus_rddata} !== {1'b0, 3'b001, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL single_ack: got %h expected %h", {a_ram_rden, a_acks, a_bus_rddata}, {1'b0, 3'b001, 32'hDEAD_BEEF});
      end
      a_l0_stb = 1'b0;
      tick();
      checks++;
      if ({a_ram_rden, a_acks} !== 4'b0) begin
         errors++;
         $display("FAIL single_no_dup: got %h expected 0", {a_ram_rden, a_acks});
      end
   endtask

   task automatic test_all_three();
      a_l0_addr = 15'h0100; a_l1_addr = 15'h0200; a_spr_addr = 15'h0300;
      a_l0_stb = 1'b1; a_l1_stb = 1'b1; a_spr_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks} !== {1'b1, 15'h0100, 3'b000}) begin
         errors++;
         $display("FAIL three_t1: got %h expected %h", {a_ram_rden, a_ram_addr, a_acks}, {1'b1, 15'h0100, 3'b000});
      end
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks, a_bus_rddata} !== {1'b1, 15'h0200, 3'b001, mem_word(15'h0100)}) begin
         errors++;
         $display("FAIL three_t2: got %h expected %h", {a_ram_rden, a_ram_addr, a_acks, a_bus_rddata}, {1'b1, 15'h0200, 3'b001, mem_word(15'h0100)});
      end
      a_l0_stb = 1'b0;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks, a_bus_rddata} !== {1'b1, 15'h0300, 3'b010, mem_word(15'h0200)}) begin
         errors++;
         $display("FAIL three_t3: got %h expected %h", {a_ram_rden, a_ram_addr, a_acks, a_bus_rddata}, {1'b1, 15'h0300, 3'b010, mem_word(15'h0200)});
      end
      a_l1_stb = 1'b0;
      tick();
      checks++;
      if ({a_ram_rden, a_acks, a_bus_rddata} !== {1'b0, 3'b100, mem_word(15'h0300)}) begin
         errors++;
         $display("FAIL three_t4: got %h expected %h", {a_ram_rden, a_acks, a_bus_rddata}, {1'b0, 3'b100, mem_word(15'h0300)});
      end
      a_spr_stb = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      int spr_issue = -1;
      a_l0_addr = 15'h0011; a_l1_addr = 15'h0022; a_spr_addr = 15'h0033;
      a_l0_stb = 1'b1; a_l1_stb = 1'b1; a_spr_stb = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         checks++;
         if ($countones(a_acks) > 1) begin
            errors++;
            $display("FAIL starve_onehot cycle %0d: got %b expected at most one ack", n, a_acks);
         end
         if (n == 2) begin
            checks++;
            if (dut_a.spr_wait_cnt_q !== 4'd2) begin
               errors++;
               $display("FAIL starve_cnt_wait: got %0d expected 2", dut_a.spr_wait_cnt_q);
            end
         end
         if (a_ram_rden && a_ram_addr == 15'h0033 && spr_issue < 0) begin
            spr_issue = n;
            checks++;
            if (dut_a.spr_wait_cnt_q !== 4'd0) begin
               errors++;
               $display("FAIL starve_cnt_clear: got %0d expected 0", dut_a.spr_wait_cnt_q);
            end
         end
         if (a_spr_ack) a_spr_stb = 1'b0;
      end
      checks++;
      if (spr_issue != 3) begin
         errors++;
         $display("FAIL starve_grant_cycle: got %0d expected 3", spr_issue);
      end
      a_l0_stb = 1'b0; a_l1_stb = 1'b0; a_spr_stb = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_abort();
      a_spr_addr = 15'h0400; a_spr_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr} !== {1'b1, 15'h0400}) begin
         errors++;
         $display("FAIL abort_issue: got %h expected %h", {a_ram_rden, a_ram_addr}, {1'b1, 15'h0400});
      end
      a_spr_stb = 1'b0;
      tick();
      checks++;
      if ({a_acks, a_bus_rddata} !== {3'b100, mem_word(15'h0400)}) begin
         errors++;
         $display("FAIL abort_ack: got %h expected %h", {a_acks, a_bus_rddata}, {3'b100, mem_word(15'h0400)});
      end
      a_spr_addr = 15'h0500; a_spr_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_acks} !== 4'b0) begin
         errors++;
         $display("FAIL abort_masked: got %h expected 0", {a_ram_rden, a_acks});
      end
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr} !== {1'b1, 15'h0500}) begin
         errors++;
         $display("FAIL abort_reissue: got %h expected %h", {a_ram_rden, a_ram_addr}, {1'b1, 15'h0500});
      end
      tick();
      checks++;
      if ({a_acks, a_bus_rddata} !== {3'b100, mem_word(15'h0500)}) begin
         errors++;
         $display("FAIL abort_reack: got %h expected %h", {a_acks, a_bus_rddata}, {3'b100, mem_word(15'h0500)});
      end
      a_spr_stb = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      a_l0_addr = 15'h0600; a_l1_addr = 15'h0700;
      a_l0_stb = 1'b1; a_l1_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr} !== {1'b1, 15'h0600}) begin
         errors++;
         $display("FAIL rstmid_issue: got %h expected %h", {a_ram_rden, a_ram_addr}, {1'b1, 15'h0600});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_l0_stb = 1'b0; a_l1_stb = 1'b0;
      checks++;
      if ({a_ram_rden, a_ram_addr, a_acks} !== 19'h0) begin
         errors++;
         $display("FAIL rstmid_state: got %h expected 0", {a_ram_rden, a_ram_addr, a_acks});
      end
      tick();
      checks++;
      if ({a_ram_rden, a_acks} !== 4'b0) begin
         errors++;
         $display("FAIL rstmid_no_ack: got %h expected 0", {a_ram_rden, a_acks});
      end
      a_l1_stb = 1'b1;
      tick();
      checks++;
      if ({a_ram_rden, a_ram_addr} !== {1'b1, 15'h0700}) begin
         errors++;
         $display("FAIL rstmid_fresh_issue: got %h expected %h", {a_ram_rden, a_ram_addr}, {1'b1, 15'h0700});
      end
      tick();
      checks++;
      if ({a_acks, a_bus_rddata} !== {3'b010, mem_word(15'h0700)}) begin
         errors++;
         $display("FAIL rstmid_fresh_ack: got %h expected %h", {a_acks, a_bus_rddata}, {3'b010, mem_word(15'h0700)});
      end
      a_l1_stb = 1'b0;
      tick();
   endtask

   task automatic test_latency3();
      b_l1_addr = 15'h0123; b_l1_stb = 1'b1;
      tick();
      checks++;
      if ({b_ram_rden, b_ram_addr, b_acks} !== {1'b1, 15'h0123, 3'b000}) begin
         errors++;
         $display("FAIL lat3_issue: got %h expected %h", {b_ram_rden, b_ram_addr, b_acks}, {1'b1, 15'h0123, 3'b000});
      end
      for (int k = 2; k <= 3; k++) begin
         tick();
         checks++;
         if ({b_ram_rden, b_acks} !== 4'b0) begin
            errors++;
            $display("FAIL lat3_wait cycle %0d: got %h expected 0", k, {b_ram_rden, b_acks});
         end
      end
      tick();
      checks++;
      if ({b_acks, b_bus_rddata} !== {3'b010, mem_word(15'h0123)}) begin
         errors++;
         $display("FAIL lat3_ack: got %h expected %h", {b_acks, b_bus_rddata}, {3'b010, mem_word(15'h0123)});
      end
      b_l1_stb = 1'b0;
      tick();
   endtask

   task automatic test_promote();
      b_l0_addr = 15'h00A0; b_l1_addr = 15'h00B0; b_spr_addr = 15'h00C0;
      b_l0_stb = 1'b1; b_l1_stb = 1'b1; b_spr_stb = 1'b1;
      tick();
      checks++;
      if ({b_ram_rden, b_ram_addr} !== {1'b1, 15'h00A0}) begin
         errors++;
         $display("FAIL promote_t1: got %h expected %h", {b_ram_rden, b_ram_addr}, {1'b1, 15'h00A0});
      end
      tick();
      checks++;
      if ({b_ram_rden, b_ram_addr} !== {1'b1, 15'h00C0}) begin
         errors++;
         $display("FAIL promote_t2: got %h expected %h", {b_ram_rden, b_ram_addr}, {1'b1, 15'h00C0});
      end
      tick();
      checks++;
      if ({b_ram_rden, b_ram_addr} !== {1'b1, 15'h00B0}) begin
         errors++;
         $display("FAIL promote_t3: got %h expected %h", {b_ram_rden, b_ram_addr}, {1'b1, 15'h00B0});
      end
      tick();
      checks++;
      if ({b_ram_rden, b_acks, b_bus_rddata} !== {1'b0, 3'b001, mem_word(15'h00A0)}) begin
         errors++;
         $display("FAIL promote_ack_l0: got %h expected %h", {b_ram_rden, b_acks, b_bus_rddata}, {1'b0, 3'b001, mem_word(15'h00A0)});
      end
      b_l0_stb = 1'b0;
      tick();
      checks++;
      if ({b_acks, b_bus_rddata} !== {3'b100, mem_word(15'h00C0)}) begin
         errors++;
         $display("FAIL promote_ack_spr: got %h expected %h", {b_acks, b_bus_rddata}, {3'b100, mem_word(15'h00C0)});
      end
      b_spr_stb = 1'b0;
      tick();
      checks++;
      if ({b_acks, b_bus_rddata} !== {3'b010, mem_word(15'h00B0)}) begin
         errors++;
         $display("FAIL promote_ack_l1: got %h expected %h", {b_acks, b_bus_rddata}, {3'b010, mem_word(15'h00B0)});
      end
      b_l1_stb = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      a_l0_addr = '0; a_l1_addr = '0; a_spr_addr = '0;
      a_l0_stb = 1'b0; a_l1_stb = 1'b0; a_spr_stb = 1'b0;
      b_l0_addr = '0; b_l1_addr = '0; b_spr_addr = '0;
      b_l0_stb = 1'b0; b_l1_stb = 1'b0; b_spr_stb = 1'b0;
      test_reset();
      test_single();
      test_all_three();
      test_starvation();
      test_abort();
      test_reset_mid();
      test_latency3();
      test_promote();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
